serial_add_sub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 27 ++
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_add_sub.sv | 109 ++++++++++
 tb/tb_serial_add_sub.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath: FSM states,
// operation select encodings and a counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_OVERFLOW_EN to add the signed-overflow output.
//
// state | meaning
// IDLE  | waiting for start_valid; start_ready high
// RUN   | shifting one bit per edge through the full adder
// DONE  | result held until done_ready handshake
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_sum;
    logic             bit_carry;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    assign start_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            carry_out  <= 1'b0;
            done_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry.
                        a_sr  <= a;
                        b_sr  <= (op_sub == OP_SUB) ? ~b : b;
                        carry <= op_sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_carry;
                    result <= {bit_sum, result[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        carry_out  <= bit_carry;
                        done_valid <= 1'b1;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
                        // carry still holds the carry into the MSB on this edge.
                        overflow   <= carry ^ bit_carry;
`endif
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: scoreboard of expected results,
// latency, backpressure, input-capture and mid-run reset scenarios.
module tb_serial_add_sub;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             op_sub = 1'b0;
    logic             done_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             start_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             done_valid;
    logic             busy;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a           (a),
        .b           (b),
        .result      (result),
        .carry_out   (carry_out),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic sub);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] bb;
        exp_t             e;
        bb    = sub ? ~bv : bv;
        sum   = {1'b0, av} + {1'b0, bb} + (WIDTH+1)'(sub);
        e.res = sum[WIDTH-1:0];
        e.cy  = sum[WIDTH];
        e.ov  = (av[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // One operation: hold > 0 applies that many cycles of done backpressure,
    // scramble changes the inputs every cycle while the op runs.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic sub, input int hold, input bit scramble);
        exp_t e;
        int   k;
        @(negedge clk);
        n_checks++;
        if (start_ready !== 1'b1) $display("FAIL start_ready_idle got %b want 1", start_ready);
        else n_pass++;
        a           = av;
        b           = bv;
        op_sub      = sub;
        start_valid = 1'b1;
        done_ready  = (hold == 0);
        sb.push_back(model(av, bv, sub));
        @(negedge clk);
        start_valid = 1'b0;
        k = 0;
        while (done_valid !== 1'b1 && k < 100) begin
            if (scramble) begin
                a      = WIDTH'($urandom);
                b      = WIDTH'($urandom);
                op_sub = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != WIDTH) $display("FAIL latency got %0d edges want %0d", k, WIDTH);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (result !== e.res) $display("FAIL result %h%s%h got %h want %h", av, sub ? "-" : "+", bv, result, e.res);
        else n_pass++;
        n_checks++;
        if (carry_out !== e.cy) $display("FAIL carry_out %h%s%h got %b want %b", av, sub ? "-" : "+", bv, carry_out, e.cy);
        else n_pass++;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        n_checks++;
        if (overflow !== e.ov) $display("FAIL overflow %h%s%h got %b want %b", av, sub ? "-" : "+", bv, overflow, e.ov);
        else n_pass++;
`endif
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            a           = WIDTH'($urandom);
            b           = WIDTH'($urandom);
            @(negedge clk);
            n_checks++;
            if (done_valid !== 1'b1 || result !== e.res || carry_out !== e.cy || start_ready !== 1'b0)
                $display("FAIL hold_stable cycle %0d got dv=%b res=%h cy=%b sr=%b want dv=1 res=%h cy=%b sr=0",
                         i, done_valid, result, carry_out, start_ready, e.res, e.cy);
            else n_pass++;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            n_checks++;
            if (overflow !== e.ov) $display("FAIL hold_overflow got %b want %b", overflow, e.ov);
            else n_pass++;
`endif
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL back_to_idle got dv=%b sr=%b busy=%b want 0 1 0", done_valid, start_ready, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (result !== '0 || carry_out !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL reset_state got res=%h cy=%b dv=%b busy=%b sr=%b want 00 0 0 0 1",
                     result, carry_out, done_valid, busy, start_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    endtask

    task automatic test_sub();
        do_op(8'h07, 8'h05, 1'b1, 0, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, 0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
        do_op(8'h33, 8'h33, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(8'hA5, 8'h3C, 1'b0, 5, 1'b0);
        do_op(8'h10, 8'h20, 1'b1, 3, 1'b0);
    endtask

    task automatic test_input_capture();
        do_op(8'h9C, 8'h47, 1'b1, 0, 1'b1);
        do_op(8'h6E, 8'hD1, 1'b0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a           = 8'h55;
        b           = 8'h22;
        op_sub      = 1'b0;
        done_ready  = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== '0 || carry_out !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL mid_run_reset got res=%h cy=%b dv=%b busy=%b sr=%b want 00 0 0 0 1",
                     result, carry_out, done_valid, busy, start_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h12, 8'h34, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_input_capture();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
